// File: rtl/ccd_emu_pkg.sv
// Shared constants for the CCD sensor emulator: FSM state codes, pattern
// selector codes and Bayer channel levels.
package ccd_emu_pkg;

    localparam int CNT_W = 16;
    localparam int PIX_W = 12;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEAD   = 3'd1;
    localparam state_t ST_ACTIVE = 3'd2;
    localparam state_t ST_HBLANK = 3'd3;
    localparam state_t ST_TRAIL  = 3'd4;
    localparam state_t ST_VBLANK = 3'd5;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_BAYER = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_FCNT  = 2'd3;

    localparam logic [PIX_W-1:0] G_LVL = 12'h800;
    localparam logic [PIX_W-1:0] R_LVL = 12'hFFF;
    localparam logic [PIX_W-1:0] B_LVL = 12'h000;

endpackage

// File: rtl/ccd_pattern_pixel.sv
// Combinational test-pattern generator: maps (pattern, x, y, frame fill) to a
// 12-bit raw pixel. The caller registers the result alongside line-valid.
module ccd_pattern_pixel
    import ccd_emu_pkg::*;
(
    input  logic [1:0]       pattern,
    input  logic [11:0]      x,
    input  logic [3:0]       y,
    input  logic [PIX_W-1:0] fcnt,
    output logic [PIX_W-1:0] pix
);

    // Only row parity and y[3] matter to any pattern.
    logic unused_y_bits;
    assign unused_y_bits = ^y[2:1];

    always_comb begin
        pix = '0;
        case (pattern)
            PAT_HRAMP: pix = x;
            PAT_BAYER: begin
                case ({y[0], x[0]})
                    2'b00:   pix = G_LVL;
                    2'b01:   pix = R_LVL;
                    2'b10:   pix = B_LVL;
                    default: pix = G_LVL;
                endcase
            end
            PAT_CHECK: pix = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
            PAT_FCNT:  pix = fcnt;
            default:   pix = '0;
        endcase
    end

endmodule

// File: rtl/ccd_sensor_emulator.sv
// Transmit-side CCD pixel port model: frame/line valid timing with
// programmable active size and blanking, plus selectable raw test patterns.
module ccd_sensor_emulator
    import ccd_emu_pkg::*;
#(
    parameter int ACTIVE_W = 640,
    parameter int ACTIVE_H = 480,
    parameter int H_BLANK  = 32,
    parameter int V_BLANK  = 8,
    parameter int FV_LEAD  = 2,
    parameter int FV_TRAIL = 2
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iENABLE,
    input  logic [1:0]  iPATTERN,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [11:0] oDATA,
    output logic [31:0] oFRAME_CNT,
    output logic        oBUSY
);

    localparam logic [CNT_W-1:0] X_LAST    = CNT_W'(ACTIVE_W - 1);
    localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(ACTIVE_H - 1);
    localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(FV_LEAD - 1);
    localparam logic [CNT_W-1:0] TR_LAST   = CNT_W'(FV_TRAIL - 1);
    localparam logic [31:0]      VB_CYC    = 32'(V_BLANK * (ACTIVE_W + H_BLANK));
    localparam logic [31:0]      VB_LAST   = VB_CYC - 32'd1;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   x_reg, x_next;
    logic [CNT_W-1:0]   y_reg, y_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [31:0]        vcnt_reg, vcnt_next;
    logic [1:0]         pat_reg;
    logic [PIX_W-1:0]   fill_reg;
    logic               done_reg;
    logic [31:0]        frame_cnt_reg;
    logic               fval_reg;
    logic               lval_reg;
    logic [PIX_W-1:0]   data_reg;
    logic               busy_reg;
    logic               lead_entry;
    logic               frame_done;
    logic [PIX_W-1:0]   pix;

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        cnt_next   = cnt_reg;
        vcnt_next  = vcnt_reg;
        lead_entry = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (iENABLE) begin
                    state_next = ST_LEAD;
                    lead_entry = 1'b1;
                    cnt_next   = '0;
                end
            end
            ST_LEAD: begin
                if (cnt_reg == LEAD_LAST) begin
                    state_next = ST_ACTIVE;
                    x_next     = '0;
                    y_next     = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (x_reg == X_LAST) begin
                    cnt_next   = '0;
                    state_next = (y_reg == Y_LAST) ? ST_TRAIL : ST_HBLANK;
                end else begin
                    x_next = x_reg + 1'b1;
                end
            end
            ST_HBLANK: begin
                if (cnt_reg == HB_LAST) begin
                    state_next = ST_ACTIVE;
                    x_next     = '0;
                    y_next     = y_reg + 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_TRAIL: begin
                if (cnt_reg == TR_LAST) begin
                    frame_done = 1'b1;
                    vcnt_next  = '0;
                    cnt_next   = '0;
                    // With no vertical blanking the restart decision is taken here.
                    if (VB_CYC != 32'd0) begin
                        state_next = ST_VBLANK;
                    end else if (iENABLE) begin
                        state_next = ST_LEAD;
                        lead_entry = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_VBLANK: begin
                if (vcnt_reg == VB_LAST) begin
                    cnt_next = '0;
                    if (iENABLE) begin
                        state_next = ST_LEAD;
                        lead_entry = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    vcnt_next = vcnt_reg + 32'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    ccd_pattern_pixel u_pattern_pixel (
        .pattern (pat_reg),
        .x       (x_reg[11:0]),
        .y       (y_reg[3:0]),
        .fcnt    (fill_reg),
        .pix     (pix)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg     <= ST_IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            cnt_reg       <= '0;
            vcnt_reg      <= '0;
            pat_reg       <= PAT_HRAMP;
            fill_reg      <= '0;
            done_reg      <= 1'b0;
            frame_cnt_reg <= '0;
            fval_reg      <= 1'b0;
            lval_reg      <= 1'b0;
            data_reg      <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
            vcnt_reg  <= vcnt_next;
            done_reg  <= frame_done;
            if (done_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 32'd1;
            end
            // Fill value must equal the count as visible once any pending increment lands.
            if (lead_entry) begin
                pat_reg  <= iPATTERN;
                fill_reg <= frame_cnt_reg[PIX_W-1:0] + {11'd0, done_reg}
                            + {11'd0, state_reg == ST_TRAIL};
            end
            fval_reg <= (state_reg == ST_LEAD) || (state_reg == ST_ACTIVE) ||
                        (state_reg == ST_HBLANK) || (state_reg == ST_TRAIL);
            lval_reg <= (state_reg == ST_ACTIVE);
            data_reg <= (state_reg == ST_ACTIVE) ? pix : '0;
            busy_reg <= (state_reg != ST_IDLE);
        end
    end

    assign oFVAL      = fval_reg;
    assign oLVAL      = lval_reg;
    assign oDATA      = data_reg;
    assign oFRAME_CNT = frame_cnt_reg;
    assign oBUSY      = busy_reg;

endmodule

// File: tb/tb_ccd_sensor_emulator.sv
// Bench for ccd_sensor_emulator with a small 8x4 geometry; expected frame
// timing and pixel values are derived arithmetically from the frame layout.
`timescale 1ns/1ps
module tb_ccd_sensor_emulator;

    localparam int W = 8, H = 4, HB = 3, VB = 2, LEAD = 2, TRAIL = 2;
    localparam int FV_LEN = LEAD + H*W + (H-1)*HB + TRAIL;   // 45
    localparam int VB_LEN = VB * (W + HB);                   // 22

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern;
    logic        fval;
    logic        lval;
    logic [11:0] data;
    logic [31:0] frame_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int frames_done = 0;

    ccd_sensor_emulator #(
        .ACTIVE_W (W), .ACTIVE_H (H), .H_BLANK (HB),
        .V_BLANK  (VB), .FV_LEAD (LEAD), .FV_TRAIL (TRAIL)
    ) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .iENABLE    (enable),
        .iPATTERN   (pattern),
        .oFVAL      (fval),
        .oLVAL      (lval),
        .oDATA      (data),
        .oFRAME_CNT (frame_cnt),
        .oBUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int pat, input int x, input int y, input int fc);
        case (pat)
            0: return 12'(x % 4096);
            1: begin
                if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
                else            return (x % 2 == 0) ? 12'h000 : 12'h800;
            end
            2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
            default: return 12'(fc % 4096);
        endcase
    endfunction

    task automatic wait_fval_rise(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fval === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Checks one full FVAL-high window cycle by cycle; optional input changes mid-frame.
    task automatic frame(input int pat, input int drop_en_at, input int switch_at,
                         input logic [1:0] switch_pat);
        bit ok;
        int u, xx, yy;
        bit lv;
        logic [11:0] exp_d;
        if (fval !== 1'b1) begin
            wait_fval_rise(200, ok);
            chk("fval_rise", 32'(ok), 32'd1);
        end
        for (int t = 0; t < FV_LEN; t++) begin
            if (t > 0) @(negedge clk);
            u  = t - LEAD;
            xx = (u >= 0) ? u % (W + HB) : 0;
            yy = (u >= 0) ? u / (W + HB) : 0;
            lv = (u >= 0) && (yy < H) && (xx < W);
            exp_d = lv ? ref_pix(pat, xx, yy, frames_done) : 12'h000;
            chk("fval_high", 32'(fval), 32'd1);
            chk("lval", 32'(lval), 32'(lv));
            chk("data", 32'(data), 32'(exp_d));
            chk("busy", 32'(busy), 32'd1);
            if (t == FV_LEN - 1) chk("cnt_before_fall", frame_cnt, 32'(frames_done));
            if (t == drop_en_at) enable = 1'b0;
            if (t == switch_at)  pattern = switch_pat;
        end
        @(negedge clk);
        chk("fval_fall", 32'(fval), 32'd0);
        frames_done++;
        $display("frame %0d pattern %0d checked (%0d comparisons so far)", frames_done - 1, pat, n_checks);
    endtask

    task automatic vblank(input bit expect_idle);
        int low = 0;
        for (int i = 0; i < 80; i++) begin
            if (fval === 1'b1) break;
            chk("vb_lval", 32'(lval), 32'd0);
            chk("vb_data", 32'(data), 32'd0);
            low++;
            if (low == 3) chk("frame_cnt", frame_cnt, 32'(frames_done));
            @(negedge clk);
        end
        if (expect_idle) begin
            chk("idle_no_fval", 32'(low), 32'd80);
            chk("idle_busy", 32'(busy), 32'd0);
        end else begin
            chk("vblank_len", 32'(low), 32'(VB_LEN));
        end
    endtask

    initial begin
        bit ok;
        logic [1:0] rp;
        rst_n   = 1'b0;
        enable  = 1'b0;
        pattern = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_fval", 32'(fval), 32'd0);
        chk("rst_lval", 32'(lval), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_cnt", frame_cnt, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_hold_fval", 32'(fval), 32'd0);
        chk("idle_hold_busy", 32'(busy), 32'd0);

        // Continuous frames, pattern for frame n+1 selected during frame n.
        enable = 1'b1;
        frame(0, -1, 20, 2'd2);
        vblank(1'b0);
        frame(2, -1, 30, 2'd1);
        vblank(1'b0);
        frame(1, -1, 5, 2'd3);
        vblank(1'b0);
        rp = 2'($urandom_range(0, 3));
        frame(3, -1, int'($urandom_range(3, 40)), rp);
        vblank(1'b0);
        for (int k = 0; k < 2; k++) begin
            logic [1:0] cur;
            cur = rp;
            rp  = 2'($urandom_range(0, 3));
            frame(int'(cur), -1, int'($urandom_range(3, 40)), rp);
            vblank(1'b0);
        end

        // Enable dropped mid-frame: frame and its blanking finish, then idle.
        frame(int'(rp), 10, -1, 2'd0);
        vblank(1'b1);

        // Asynchronous reset during active video.
        pattern = 2'd0;
        enable  = 1'b1;
        wait_fval_rise(200, ok);
        chk("rst_run_rise", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
        chk("pre_rst_lval", 32'(lval), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_fval", 32'(fval), 32'd0);
        chk("async_lval", 32'(lval), 32'd0);
        chk("async_data", 32'(data), 32'd0);
        chk("async_cnt", frame_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frames_done = 0;
        frame(0, -1, -1, 2'd0);
        vblank(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccd_sensor_emulator.md
Name: ccd_sensor_emulator

Overview:
Transmit-side model of the CCD sensor pixel port. It generates frame-valid, line-valid and 12-bit Bayer raw data with programmable active size and blanking. It drives the capture path (capture → RAW2RGB) on the board when no camera is fitted, and it acts as the stimulus source in system simulation. All outputs are synchronous to the one clock; the downstream capture logic samples them on the same clock edge.

Parameters:
ACTIVE_W, 640, active pixels per line (≥2)
ACTIVE_H, 480, active lines per frame (≥2)
H_BLANK, 32, LVAL-low cycles between lines (≥1)
V_BLANK, 8, blank lines between frames; FVAL low for V_BLANK*(ACTIVE_W+H_BLANK) cycles
FV_LEAD, 2, cycles FVAL high before the first LVAL (≥1)
FV_TRAIL, 2, cycles FVAL high after the last LVAL (≥1)

Ports:
iCLK  in  1  pixel clock; all logic on the rising edge
iRST_N  in  1  asynchronous active-low reset
iENABLE  in  1  level; 1 = emit frames continuously
iPATTERN  in  2  0 = H ramp, 1 = Bayer flat field, 2 = checkerboard, 3 = frame-count fill
oFVAL  out  1  frame valid
oLVAL  out  1  line valid (only high while oFVAL = 1)
oDATA  out  12  raw pixel; 0 whenever oLVAL = 0
oFRAME_CNT  out  32  completed-frame count
oBUSY  out  1  1 whenever state ≠ IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE. oFVAL, oLVAL, oBUSY = 0; oDATA = 0; oFRAME_CNT = 0; x/y counters = 0.
- All outputs are registered. The state decoded in cycle n appears on the outputs in cycle n+1.
- FSM states and transitions:
  - IDLE: FVAL = 0. Moves to LEAD on the first cycle iENABLE = 1.
  - LEAD: FVAL = 1, LVAL = 0 for FV_LEAD cycles, then ACTIVE.
  - ACTIVE: FVAL = 1, LVAL = 1 for ACTIVE_W cycles; x counts 0..ACTIVE_W-1. Then HBLANK if y < ACTIVE_H-1, else TRAIL.
  - HBLANK: FVAL = 1, LVAL = 0 for H_BLANK cycles; y increments; then ACTIVE.
  - TRAIL: FVAL = 1, LVAL = 0 for FV_TRAIL cycles, then VBLANK.
  - VBLANK: FVAL = 0 for V_BLANK*(ACTIVE_W+H_BLANK) cycles, then LEAD if iENABLE = 1, else IDLE. If V_BLANK = 0, go straight to the LEAD/IDLE decision.
- FVAL high length per frame = FV_LEAD + ACTIVE_H*ACTIVE_W + (ACTIVE_H-1)*H_BLANK + FV_TRAIL.
- iPATTERN is latched on entry to LEAD and held for the whole frame. Mid-frame changes take effect next frame.
- iENABLE deasserted mid-frame: the current frame completes, including VBLANK, and then the FSM goes to IDLE. No truncated frames.
- oFRAME_CNT increments by 1 in the cycle after the FVAL falling edge (TRAIL→VBLANK) and wraps at 2^32-1 → 0.
- Pixel value at (x, y), valid only while LVAL = 1; oDATA = 0 otherwise:
  - Pattern 0: x[11:0], mod 4096.
  - Pattern 1: Bayer G R / B G. Even row, even col = 12'h800 (G); even row, odd col = 12'hFFF (R); odd row, even col = 12'h000 (B); odd row, odd col = 12'h800 (G).
  - Pattern 2: (x[3]^y[3]) ? 12'hFFF : 12'h000.
  - Pattern 3: latched frame count [11:0]. This is the oFRAME_CNT value at LEAD entry.
- Counter widths: 16 bits each for x, y and the blank counter. The VBLANK counter is 32 bits.
- Reset asserted mid-frame: outputs go low immediately (asynchronous). After release, the FSM restarts from IDLE.

Decomposition:
- Shared package ccd_emu_pkg:
  - state enum (IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK)
  - pattern code constants PAT_HRAMP, PAT_BAYER, PAT_CHECK, PAT_FCNT
  - Bayer constants G_LVL = 12'h800, R_LVL = 12'hFFF, B_LVL = 12'h000
- One sub-module, ccd_pattern_pixel. It is combinational: (pattern, x, y, fcnt) → 12-bit pixel. The top level registers its output together with LVAL.

Test Plan:
All scenarios use ACTIVE_W = 8, ACTIVE_H = 4, H_BLANK = 3, V_BLANK = 2, FV_LEAD = 2, FV_TRAIL = 2.
1. Reset, then iENABLE = 1, pattern 0 → FVAL high for exactly 45 cycles; 4 LVAL pulses of 8 cycles separated by 3 low cycles; first LVAL 2 cycles after FVAL rise; oDATA = 0,1,…,7 on each line.
2. Continuous enable → FVAL low for exactly 22 cycles between frames; oFRAME_CNT reads 1, 2, 3 after successive FVAL falls.
3. Pattern 1 → line 0 data 800,FFF repeating; line 1 data 000,800 repeating; oDATA = 0 during every blank.
4. iPATTERN switched 0→2 in the middle of frame 0 → frame 0 stays a ramp; frame 1 is checkerboard; with ACTIVE_W = 8, all pixels are 000 (x[3] = y[3] = 0).
5. iENABLE dropped at cycle 10 of a frame → that frame completes (45 FVAL cycles, 22 VBLANK cycles), then IDLE with oBUSY = 0 and no further FVAL.
6. iRST_N pulsed low during ACTIVE → oFVAL, oLVAL, oDATA go to 0 without waiting for a clock edge; oFRAME_CNT = 0; a full 45-cycle frame follows after release with iENABLE = 1.
